// File: rtl/vram_write_queue_if.sv
// vram_write_queue_if
//   Bundles the CPU-side capture signals, the optional clear-engine controls and the
//   VRAM write port that feeds the display block.
//   master : the host side (drives CPU writes and clear requests, observes VRAM port)
//   slave  : the queue itself
//   Signals:
//     cpu_addr/cpu_dout/cpu_we/color_in : CPU write capture
//     cpu_wait                           : queue full, CPU must stall
//     clr_start/clr_data/clr_color       : clear request and fill pattern
//     busy/clr_done                      : clear engine status
//     addr/din/color/we                  : VRAM write port
interface vram_write_queue_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  color_in;
    logic        cpu_wait;
    logic        clr_start;
    logic [7:0]  clr_data;
    logic [7:0]  clr_color;
    logic        busy;
    logic        clr_done;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  color;
    logic        we;

    modport master (
        output cpu_addr, cpu_dout, cpu_we, color_in, clr_start, clr_data, clr_color,
        input  cpu_wait, busy, clr_done, addr, din, color, we
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_we, color_in, clr_start, clr_data, clr_color,
        output cpu_wait, busy, clr_done, addr, din, color, we
    );
endinterface

// File: rtl/vram_write_queue.sv
// vram_write_queue
//   Captures CPU writes that fall in the screen window [ADDR_LO, ADDR_HI], tags each with
//   the colour latch sampled in the same cycle, queues them in a DEPTH-entry FIFO and
//   drains one write per clock onto the display VRAM port.
//   Optional screen-clear engine, enabled by defining the macro VRAM_CLR_EN: waits for the
//   FIFO to empty, then fills the whole window with clr_data/clr_color, then pulses
//   clr_done. CPU writes arriving during the fill are held and drain afterwards.
//   Ports:
//     clk_sys  : system clock
//     reset_n  : asynchronous active-low reset
//     bus      : vram_write_queue_if.slave (CPU capture, clear control, VRAM write port)
module vram_write_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] ADDR_LO = 16'h9000,
    parameter logic [15:0] ADDR_HI = 16'hBFFF
) (
    input logic               clk_sys,
    input logic               reset_n,
    vram_write_queue_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  color;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            in_window, not_empty, push, pop;

    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  color_q, color_d;
    logic        we_q, we_d;
    logic        cpu_wait_q, cpu_wait_d;

`ifdef VRAM_CLR_EN
    typedef enum logic [1:0] {StIdle, StWaitEmpty, StClear, StDone} state_e;
    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic        busy_q, busy_d;
    logic        clr_done_q, clr_done_d;
`endif

    assign in_window = (bus.cpu_addr >= ADDR_LO) && (bus.cpu_addr <= ADDR_HI);
    assign not_empty = (count_q != '0);
    // Full is judged on the pre-edge count, so a write arriving while full is dropped even
    // if a pop happens on the same edge.
    assign push      = bus.cpu_we && in_window && (count_q != CntW'(DEPTH));
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        pop     = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        color_d = color_q;
        we_d    = 1'b0;
`ifdef VRAM_CLR_EN
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                pop = not_empty;
                if (bus.clr_start) begin
                    state_d = StWaitEmpty;
                end
            end
            StWaitEmpty: begin
                if (not_empty) begin
                    pop = 1'b1;
                end else begin
                    ptr_d   = ADDR_LO;
                    state_d = StClear;
                end
            end
            StClear: begin
                addr_d  = ptr_q;
                din_d   = bus.clr_data;
                color_d = bus.clr_color;
                we_d    = 1'b1;
                ptr_d   = ptr_q + 16'd1;
                if (ptr_q == ADDR_HI) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                clr_done_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // busy covers the cycle in which the last fill write is on the port; it drops
        // together with the rise of clr_done.
        busy_d = (state_d != StIdle);
`else
        pop = not_empty;
`endif
        if (pop) begin
            addr_d  = head.addr;
            din_d   = head.data;
            color_d = head.color;
            we_d    = 1'b1;
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        cpu_wait_d = (count_d == CntW'(DEPTH));
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: bus.cpu_addr, data: bus.cpu_dout, color: bus.color_in};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            color_q    <= '0;
            we_q       <= 1'b0;
            cpu_wait_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            color_q    <= color_d;
            we_q       <= we_d;
            cpu_wait_q <= cpu_wait_d;
        end
    end

`ifdef VRAM_CLR_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.clr_done = clr_done_q;
`else
    assign bus.busy     = 1'b0;
    assign bus.clr_done = 1'b0;
`endif

    assign bus.addr     = addr_q;
    assign bus.din      = din_q;
    assign bus.color    = color_q;
    assign bus.we       = we_q;
    assign bus.cpu_wait = cpu_wait_q;
endmodule
